// File: rtl/axi4_ddr_arbiter_if.sv
// Bus bundle for the two-master DDR4 AXI4 arbiter.
// s0_/s1_ are the upstream masters, m_ is the memory-shell slave port.
interface axi4_ddr_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int ID_W   = 6
);
    localparam int STRB_W = DATA_W / 8;

    // master 0
    logic [ID_W-1:0]   s0_awid;
    logic [ADDR_W-1:0] s0_awaddr;
    logic [7:0]        s0_awlen;
    logic [2:0]        s0_awsize;
    logic [1:0]        s0_awburst;
    logic              s0_awvalid;
    logic              s0_awready;
    logic [DATA_W-1:0] s0_wdata;
    logic [STRB_W-1:0] s0_wstrb;
    logic              s0_wlast;
    logic              s0_wvalid;
    logic              s0_wready;
    logic [ID_W-1:0]   s0_bid;
    logic [1:0]        s0_bresp;
    logic              s0_bvalid;
    logic              s0_bready;
    logic [ID_W-1:0]   s0_arid;
    logic [ADDR_W-1:0] s0_araddr;
    logic [7:0]        s0_arlen;
    logic [2:0]        s0_arsize;
    logic [1:0]        s0_arburst;
    logic              s0_arvalid;
    logic              s0_arready;
    logic [ID_W-1:0]   s0_rid;
    logic [DATA_W-1:0] s0_rdata;
    logic [1:0]        s0_rresp;
    logic              s0_rlast;
    logic              s0_rvalid;
    logic              s0_rready;

    // master 1
    logic [ID_W-1:0]   s1_awid;
    logic [ADDR_W-1:0] s1_awaddr;
    logic [7:0]        s1_awlen;
    logic [2:0]        s1_awsize;
    logic [1:0]        s1_awburst;
    logic              s1_awvalid;
    logic              s1_awready;
    logic [DATA_W-1:0] s1_wdata;
    logic [STRB_W-1:0] s1_wstrb;
    logic              s1_wlast;
    logic              s1_wvalid;
    logic              s1_wready;
    logic [ID_W-1:0]   s1_bid;
    logic [1:0]        s1_bresp;
    logic              s1_bvalid;
    logic              s1_bready;
    logic [ID_W-1:0]   s1_arid;
    logic [ADDR_W-1:0] s1_araddr;
    logic [7:0]        s1_arlen;
    logic [2:0]        s1_arsize;
    logic [1:0]        s1_arburst;
    logic              s1_arvalid;
    logic              s1_arready;
    logic [ID_W-1:0]   s1_rid;
    logic [DATA_W-1:0] s1_rdata;
    logic [1:0]        s1_rresp;
    logic              s1_rlast;
    logic              s1_rvalid;
    logic              s1_rready;

    // slave side, ID widened by the master tag
    logic [ID_W:0]     m_awid;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_awvalid;
    logic              m_awready;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              m_wlast;
    logic              m_wvalid;
    logic              m_wready;
    logic [ID_W:0]     m_bid;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [ID_W:0]     m_arid;
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready;
    logic [ID_W:0]     m_rid;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;

    // arbiter view
    modport slave (
        input  s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awvalid,
        output s0_awready,
        input  s0_wdata, s0_wstrb, s0_wlast, s0_wvalid,
        output s0_wready,
        output s0_bid, s0_bresp, s0_bvalid,
        input  s0_bready,
        input  s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arvalid,
        output s0_arready,
        output s0_rid, s0_rdata, s0_rresp, s0_rlast, s0_rvalid,
        input  s0_rready,
        input  s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awvalid,
        output s1_awready,
        input  s1_wdata, s1_wstrb, s1_wlast, s1_wvalid,
        output s1_wready,
        output s1_bid, s1_bresp, s1_bvalid,
        input  s1_bready,
        input  s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arvalid,
        output s1_arready,
        output s1_rid, s1_rdata, s1_rresp, s1_rlast, s1_rvalid,
        input  s1_rready,
        output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bid, m_bresp, m_bvalid,
        output m_bready,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready
    );

    // environment view: upstream masters plus memory shell
    modport master (
        output s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awvalid,
        input  s0_awready,
        output s0_wdata, s0_wstrb, s0_wlast, s0_wvalid,
        input  s0_wready,
        input  s0_bid, s0_bresp, s0_bvalid,
        output s0_bready,
        output s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arvalid,
        input  s0_arready,
        input  s0_rid, s0_rdata, s0_rresp, s0_rlast, s0_rvalid,
        output s0_rready,
        output s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awvalid,
        input  s1_awready,
        output s1_wdata, s1_wstrb, s1_wlast, s1_wvalid,
        input  s1_wready,
        input  s1_bid, s1_bresp, s1_bvalid,
        output s1_bready,
        output s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arvalid,
        input  s1_arready,
        input  s1_rid, s1_rdata, s1_rresp, s1_rlast, s1_rvalid,
        output s1_rready,
        input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bid, m_bresp, m_bvalid,
        input  m_bready,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready
    );
endinterface

// File: rtl/axi4_ddr_arbiter.sv
// Two-master AXI4 arbiter in front of the DDR4 slave port (mc_clk domain).
// Optional AXI4_DDR_ARB_PERF_CNT_EN adds AW/AR handshake counters.
module axi4_ddr_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 512,
    parameter int ID_W        = 6,
    parameter int WFIFO_DEPTH = 8
) (
    input  logic mc_clk,
    input  logic mc_rst,
    input  logic calib_done,
    axi4_ddr_arbiter_if.slave bus
`ifdef AXI4_DDR_ARB_PERF_CNT_EN
    ,
    input  logic        perf_clr,
    output logic [31:0] perf_aw_cnt0,
    output logic [31:0] perf_aw_cnt1,
    output logic [31:0] perf_ar_cnt0,
    output logic [31:0] perf_ar_cnt1
`endif
);
    localparam int PTR_W  = $clog2(WFIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    arb_state_e aw_state_q, aw_state_d;
    arb_state_e ar_state_q, ar_state_d;
    logic       aw_last_q, aw_last_d;
    logic       ar_last_q, ar_last_d;
    logic       aw_hs;
    logic       ar_hs;

    logic             wf_mem_q [WFIFO_DEPTH];
    logic [PTR_W-1:0] wf_wr_q;
    logic [PTR_W-1:0] wf_rd_q;
    logic [CNT_W-1:0] wf_cnt_q;
    logic             wf_full;
    logic             wf_empty;
    logic             wf_head;
    logic             w_pop;
    logic             b_sel;
    logic             r_sel;

    assign wf_full  = (wf_cnt_q == CNT_W'(WFIFO_DEPTH));
    assign wf_empty = (wf_cnt_q == '0);
    assign wf_head  = wf_mem_q[wf_rd_q];

    // round-robin pick: the requester that was not granted last wins a tie
    function automatic arb_state_e pick(logic r0, logic r1, logic last);
        if (r0 && r1) begin
            return last ? GNT0 : GNT1;
        end else if (r0) begin
            return GNT0;
        end
        return GNT1;
    endfunction

    // arbiter state and last-granted pointers
    always_ff @(posedge mc_clk) begin
        if (mc_rst) begin
            aw_state_q <= IDLE;
            ar_state_q <= IDLE;
            aw_last_q  <= 1'b1;
            ar_last_q  <= 1'b1;
        end else begin
            aw_state_q <= aw_state_d;
            ar_state_q <= ar_state_d;
            aw_last_q  <= aw_last_d;
            ar_last_q  <= ar_last_d;
        end
    end

    // AW grant FSM and address mux
    always_comb begin
        aw_state_d     = aw_state_q;
        aw_last_d      = aw_last_q;
        aw_hs          = 1'b0;
        bus.m_awid     = '0;
        bus.m_awaddr   = {ADDR_W{1'b0}};
        bus.m_awlen    = '0;
        bus.m_awsize   = '0;
        bus.m_awburst  = '0;
        bus.m_awvalid  = 1'b0;
        bus.s0_awready = 1'b0;
        bus.s1_awready = 1'b0;
        case (aw_state_q)
            IDLE: begin
                if (calib_done && !wf_full &&
                    (bus.s0_awvalid || bus.s1_awvalid)) begin
                    aw_state_d = pick(bus.s0_awvalid, bus.s1_awvalid,
                                      aw_last_q);
                end
            end
            GNT0: begin
                bus.m_awid     = {1'b0, bus.s0_awid};
                bus.m_awaddr   = bus.s0_awaddr;
                bus.m_awlen    = bus.s0_awlen;
                bus.m_awsize   = bus.s0_awsize;
                bus.m_awburst  = bus.s0_awburst;
                bus.m_awvalid  = bus.s0_awvalid;
                bus.s0_awready = bus.m_awready;
                if (bus.s0_awvalid && bus.m_awready) begin
                    aw_hs      = 1'b1;
                    aw_last_d  = 1'b0;
                    aw_state_d = IDLE;
                end
            end
            GNT1: begin
                bus.m_awid     = {1'b1, bus.s1_awid};
                bus.m_awaddr   = bus.s1_awaddr;
                bus.m_awlen    = bus.s1_awlen;
                bus.m_awsize   = bus.s1_awsize;
                bus.m_awburst  = bus.s1_awburst;
                bus.m_awvalid  = bus.s1_awvalid;
                bus.s1_awready = bus.m_awready;
                if (bus.s1_awvalid && bus.m_awready) begin
                    aw_hs      = 1'b1;
                    aw_last_d  = 1'b1;
                    aw_state_d = IDLE;
                end
            end
            default: aw_state_d = IDLE;
        endcase
    end

    // AR grant FSM and address mux, independent of the write path
    always_comb begin
        ar_state_d     = ar_state_q;
        ar_last_d      = ar_last_q;
        ar_hs          = 1'b0;
        bus.m_arid     = '0;
        bus.m_araddr   = {ADDR_W{1'b0}};
        bus.m_arlen    = '0;
        bus.m_arsize   = '0;
        bus.m_arburst  = '0;
        bus.m_arvalid  = 1'b0;
        bus.s0_arready = 1'b0;
        bus.s1_arready = 1'b0;
        case (ar_state_q)
            IDLE: begin
                if (calib_done && (bus.s0_arvalid || bus.s1_arvalid)) begin
                    ar_state_d = pick(bus.s0_arvalid, bus.s1_arvalid,
                                      ar_last_q);
                end
            end
            GNT0: begin
                bus.m_arid     = {1'b0, bus.s0_arid};
                bus.m_araddr   = bus.s0_araddr;
                bus.m_arlen    = bus.s0_arlen;
                bus.m_arsize   = bus.s0_arsize;
                bus.m_arburst  = bus.s0_arburst;
                bus.m_arvalid  = bus.s0_arvalid;
                bus.s0_arready = bus.m_arready;
                if (bus.s0_arvalid && bus.m_arready) begin
                    ar_hs      = 1'b1;
                    ar_last_d  = 1'b0;
                    ar_state_d = IDLE;
                end
            end
            GNT1: begin
                bus.m_arid     = {1'b1, bus.s1_arid};
                bus.m_araddr   = bus.s1_araddr;
                bus.m_arlen    = bus.s1_arlen;
                bus.m_arsize   = bus.s1_arsize;
                bus.m_arburst  = bus.s1_arburst;
                bus.m_arvalid  = bus.s1_arvalid;
                bus.s1_arready = bus.m_arready;
                if (bus.s1_arvalid && bus.m_arready) begin
                    ar_hs      = 1'b1;
                    ar_last_d  = 1'b1;
                    ar_state_d = IDLE;
                end
            end
            default: ar_state_d = IDLE;
        endcase
    end

    // W order FIFO: one entry per granted AW, popped on the last W beat
    always_ff @(posedge mc_clk) begin
        if (mc_rst) begin
            wf_wr_q  <= '0;
            wf_rd_q  <= '0;
            wf_cnt_q <= '0;
        end else begin
            if (aw_hs) begin
                wf_mem_q[wf_wr_q] <= (aw_state_q == GNT1);
                wf_wr_q           <= wf_wr_q + 1'b1;
            end
            if (w_pop) begin
                wf_rd_q <= wf_rd_q + 1'b1;
            end
            case ({aw_hs, w_pop})
                2'b10:   wf_cnt_q <= wf_cnt_q + CNT_W'(1);
                2'b01:   wf_cnt_q <= wf_cnt_q - CNT_W'(1);
                default: wf_cnt_q <= wf_cnt_q;
            endcase
        end
    end

    // W data steered from the master at the FIFO head
    always_comb begin
        bus.m_wdata   = {DATA_W{1'b0}};
        bus.m_wstrb   = {STRB_W{1'b0}};
        bus.m_wlast   = 1'b0;
        bus.m_wvalid  = 1'b0;
        bus.s0_wready = 1'b0;
        bus.s1_wready = 1'b0;
        if (!wf_empty) begin
            if (wf_head) begin
                bus.m_wdata   = bus.s1_wdata;
                bus.m_wstrb   = bus.s1_wstrb;
                bus.m_wlast   = bus.s1_wlast;
                bus.m_wvalid  = bus.s1_wvalid;
                bus.s1_wready = bus.m_wready;
            end else begin
                bus.m_wdata   = bus.s0_wdata;
                bus.m_wstrb   = bus.s0_wstrb;
                bus.m_wlast   = bus.s0_wlast;
                bus.m_wvalid  = bus.s0_wvalid;
                bus.s0_wready = bus.m_wready;
            end
        end
    end

    assign w_pop = !wf_empty && bus.m_wvalid && bus.m_wready && bus.m_wlast;

    assign b_sel = bus.m_bid[ID_W];
    assign r_sel = bus.m_rid[ID_W];

    // B responses routed by the tag bit in the ID MSB
    always_comb begin
        bus.s0_bid    = '0;
        bus.s0_bresp  = '0;
        bus.s0_bvalid = 1'b0;
        bus.s1_bid    = '0;
        bus.s1_bresp  = '0;
        bus.s1_bvalid = 1'b0;
        if (b_sel) begin
            bus.s1_bid    = bus.m_bid[ID_W-1:0];
            bus.s1_bresp  = bus.m_bresp;
            bus.s1_bvalid = bus.m_bvalid;
            bus.m_bready  = bus.s1_bready;
        end else begin
            bus.s0_bid    = bus.m_bid[ID_W-1:0];
            bus.s0_bresp  = bus.m_bresp;
            bus.s0_bvalid = bus.m_bvalid;
            bus.m_bready  = bus.s0_bready;
        end
    end

    // R beats routed by the tag bit in the ID MSB
    always_comb begin
        bus.s0_rid    = '0;
        bus.s0_rdata  = {DATA_W{1'b0}};
        bus.s0_rresp  = '0;
        bus.s0_rlast  = 1'b0;
        bus.s0_rvalid = 1'b0;
        bus.s1_rid    = '0;
        bus.s1_rdata  = {DATA_W{1'b0}};
        bus.s1_rresp  = '0;
        bus.s1_rlast  = 1'b0;
        bus.s1_rvalid = 1'b0;
        if (r_sel) begin
            bus.s1_rid    = bus.m_rid[ID_W-1:0];
            bus.s1_rdata  = bus.m_rdata;
            bus.s1_rresp  = bus.m_rresp;
            bus.s1_rlast  = bus.m_rlast;
            bus.s1_rvalid = bus.m_rvalid;
            bus.m_rready  = bus.s1_rready;
        end else begin
            bus.s0_rid    = bus.m_rid[ID_W-1:0];
            bus.s0_rdata  = bus.m_rdata;
            bus.s0_rresp  = bus.m_rresp;
            bus.s0_rlast  = bus.m_rlast;
            bus.s0_rvalid = bus.m_rvalid;
            bus.m_rready  = bus.s0_rready;
        end
    end

`ifdef AXI4_DDR_ARB_PERF_CNT_EN
    logic [31:0] paw0_q, paw1_q, par0_q, par1_q;

    // per-master handshake counters; clear beats a same-cycle increment
    always_ff @(posedge mc_clk) begin
        if (mc_rst || perf_clr) begin
            paw0_q <= '0;
            paw1_q <= '0;
            par0_q <= '0;
            par1_q <= '0;
        end else begin
            if (aw_hs && aw_state_q == GNT0) paw0_q <= paw0_q + 32'd1;
            if (aw_hs && aw_state_q == GNT1) paw1_q <= paw1_q + 32'd1;
            if (ar_hs && ar_state_q == GNT0) par0_q <= par0_q + 32'd1;
            if (ar_hs && ar_state_q == GNT1) par1_q <= par1_q + 32'd1;
        end
    end

    assign perf_aw_cnt0 = paw0_q;
    assign perf_aw_cnt1 = paw1_q;
    assign perf_ar_cnt0 = par0_q;
    assign perf_ar_cnt1 = par1_q;
`endif
endmodule

// File: tb/tb_axi4_ddr_arbiter.sv
// Directed bench for axi4_ddr_arbiter.
// Optional AXI4_DDR_ARB_PERF_CNT_EN also exercises the perf counters.
module tb_axi4_ddr_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int ID_W   = 6;

    logic mc_clk;
    logic mc_rst;
    logic calib_done;
    int   total;
    int   bad;

`ifdef AXI4_DDR_ARB_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] perf_aw_cnt0, perf_aw_cnt1, perf_ar_cnt0, perf_ar_cnt1;
`endif

    axi4_ddr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    axi4_ddr_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .WFIFO_DEPTH(8)
    ) dut (
        .mc_clk(mc_clk),
        .mc_rst(mc_rst),
        .calib_done(calib_done),
        .bus(bus)
`ifdef AXI4_DDR_ARB_PERF_CNT_EN
        ,
        .perf_clr(perf_clr),
        .perf_aw_cnt0(perf_aw_cnt0),
        .perf_aw_cnt1(perf_aw_cnt1),
        .perf_ar_cnt0(perf_ar_cnt0),
        .perf_ar_cnt1(perf_ar_cnt1)
`endif
    );

    initial mc_clk = 1'b0;
    always #5 mc_clk = ~mc_clk;

    task automatic tick();
        @(posedge mc_clk);
        #1;
    endtask

    task automatic init_inputs();
        bus.s0_awid = '0; bus.s0_awaddr = '0; bus.s0_awlen = 8'd3;
        bus.s0_awsize = 3'd6; bus.s0_awburst = 2'd1; bus.s0_awvalid = 1'b0;
        bus.s0_wdata = '0; bus.s0_wstrb = '1; bus.s0_wlast = 1'b0;
        bus.s0_wvalid = 1'b0; bus.s0_bready = 1'b0;
        bus.s0_arid = '0; bus.s0_araddr = '0; bus.s0_arlen = 8'd0;
        bus.s0_arsize = 3'd6; bus.s0_arburst = 2'd1; bus.s0_arvalid = 1'b0;
        bus.s0_rready = 1'b0;
        bus.s1_awid = '0; bus.s1_awaddr = '0; bus.s1_awlen = 8'd3;
        bus.s1_awsize = 3'd6; bus.s1_awburst = 2'd1; bus.s1_awvalid = 1'b0;
        bus.s1_wdata = '0; bus.s1_wstrb = '1; bus.s1_wlast = 1'b0;
        bus.s1_wvalid = 1'b0; bus.s1_bready = 1'b0;
        bus.s1_arid = '0; bus.s1_araddr = '0; bus.s1_arlen = 8'd0;
        bus.s1_arsize = 3'd6; bus.s1_arburst = 2'd1; bus.s1_arvalid = 1'b0;
        bus.s1_rready = 1'b0;
        bus.m_awready = 1'b0; bus.m_wready = 1'b0;
        bus.m_bid = '0; bus.m_bresp = '0; bus.m_bvalid = 1'b0;
        bus.m_arready = 1'b0;
        bus.m_rid = '0; bus.m_rdata = '0; bus.m_rresp = '0;
        bus.m_rlast = 1'b0; bus.m_rvalid = 1'b0;
`ifdef AXI4_DDR_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        mc_rst = 1'b1;
        tick();
        tick();
        mc_rst = 1'b0;
    endtask

    task automatic test_reset();
        mc_rst = 1'b1;
        calib_done = 1'b0;
        init_inputs();
        tick();
        tick();
        total++; if (bus.m_awvalid !== 1'b0) begin bad++; $display("FAIL rst_m_awvalid got=%0b want=0", bus.m_awvalid); end
        total++; if (bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL rst_m_arvalid got=%0b want=0", bus.m_arvalid); end
        total++; if (bus.m_wvalid !== 1'b0) begin bad++; $display("FAIL rst_m_wvalid got=%0b want=0", bus.m_wvalid); end
        total++; if (bus.s0_awready !== 1'b0) begin bad++; $display("FAIL rst_s0_awready got=%0b want=0", bus.s0_awready); end
        total++; if (bus.s1_arready !== 1'b0) begin bad++; $display("FAIL rst_s1_arready got=%0b want=0", bus.s1_arready); end
        total++; if (bus.s0_wready !== 1'b0) begin bad++; $display("FAIL rst_s0_wready got=%0b want=0", bus.s0_wready); end
        total++; if (bus.s0_bvalid !== 1'b0) begin bad++; $display("FAIL rst_s0_bvalid got=%0b want=0", bus.s0_bvalid); end
        mc_rst = 1'b0;
        tick();
    endtask

    task automatic test_calib_gate();
        bus.s0_arid = 6'h2A;
        bus.s0_araddr = 64'h0000_0000_0000_1000;
        bus.s0_arvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++; if (bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL calib_hold_arvalid cyc=%0d got=%0b want=0", c, bus.m_arvalid); end
        end
        total++; if (bus.s0_arready !== 1'b0) begin bad++; $display("FAIL calib_hold_arready got=%0b want=0", bus.s0_arready); end
        calib_done = 1'b1;
        #1;
        total++; if (bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL calib_same_cycle got=%0b want=0", bus.m_arvalid); end
        tick();
        total++; if (bus.m_arvalid !== 1'b1) begin bad++; $display("FAIL calib_grant_arvalid got=%0b want=1", bus.m_arvalid); end
        total++; if (bus.m_arid !== 7'h2A) begin bad++; $display("FAIL calib_grant_arid got=%h want=2a", bus.m_arid); end
        total++; if (bus.m_araddr !== 64'h1000) begin bad++; $display("FAIL calib_grant_araddr got=%h want=1000", bus.m_araddr); end
        bus.m_arready = 1'b1;
        #1;
        total++; if (bus.s0_arready !== 1'b1) begin bad++; $display("FAIL calib_arready got=%0b want=1", bus.s0_arready); end
        tick();
        bus.s0_arvalid = 1'b0;
        bus.m_arready = 1'b0;
        #1;
        total++; if (bus.m_arvalid !== 1'b0) begin bad++; $display("FAIL calib_after_hs got=%0b want=0", bus.m_arvalid); end
    endtask

    task automatic test_aw_round_robin();
        logic [6:0] ids [4];
        logic [6:0] exp_id [4];
        int n;
        exp_id[0] = 7'h11; exp_id[1] = 7'h62;
        exp_id[2] = 7'h11; exp_id[3] = 7'h62;
        for (int i = 0; i < 4; i++) ids[i] = '0;
        bus.s0_awid = 6'h11;
        bus.s1_awid = 6'h22;
        bus.s0_awvalid = 1'b1;
        bus.s1_awvalid = 1'b1;
        bus.m_awready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            if (bus.m_awvalid) begin
                ids[n] = bus.m_awid;
                n++;
            end
        end
        tick();
        bus.s0_awvalid = 1'b0;
        bus.s1_awvalid = 1'b0;
        total++; if (n !== 4) begin bad++; $display("FAIL rr_grant_count got=%0d want=4", n); end
        for (int i = 0; i < 4; i++) begin
            total++; if (ids[i] !== exp_id[i]) begin bad++; $display("FAIL rr_awid idx=%0d got=%h want=%h", i, ids[i], exp_id[i]); end
        end
        tick();
        total++; if (bus.m_awvalid !== 1'b0) begin bad++; $display("FAIL rr_idle_after got=%0b want=0", bus.m_awvalid); end
    endtask

    task automatic test_w_order();
        logic [15:0] got [16];
        logic [15:0] exp_w;
        int n, b0, b1;
        logic h0, h1;
        for (int i = 0; i < 16; i++) got[i] = '0;
        n = 0; b0 = 0; b1 = 0;
        bus.m_wready = 1'b1;
        for (int c = 0; c < 40 && n < 16; c++) begin
            bus.s0_wvalid = (b0 < 8);
            bus.s0_wdata  = {{(DATA_W-16){1'b0}}, 8'h00, 8'(b0)};
            bus.s0_wlast  = (b0 % 4 == 3);
            bus.s1_wvalid = (b1 < 8);
            bus.s1_wdata  = {{(DATA_W-16){1'b0}}, 8'h01, 8'(b1)};
            bus.s1_wlast  = (b1 % 4 == 3);
            #1;
            h0 = bus.s0_wvalid && bus.s0_wready;
            h1 = bus.s1_wvalid && bus.s1_wready;
            if (bus.m_wvalid && bus.m_wready) begin
                got[n] = bus.m_wdata[15:0];
                n++;
            end
            tick();
            if (h0) b0++;
            if (h1) b1++;
        end
        total++; if (n !== 16) begin bad++; $display("FAIL w_beat_count got=%0d want=16", n); end
        for (int k = 0; k < 16; k++) begin
            exp_w = {8'((k / 4) % 2), 8'((k / 8) * 4 + k % 4)};
            total++; if (got[k] !== exp_w) begin bad++; $display("FAIL w_order beat=%0d got=%h want=%h", k, got[k], exp_w); end
        end
        bus.s0_wvalid = 1'b1;
        bus.s1_wvalid = 1'b1;
        #1;
        total++; if (bus.m_wvalid !== 1'b0) begin bad++; $display("FAIL w_empty_wvalid got=%0b want=0", bus.m_wvalid); end
        total++; if (bus.s0_wready !== 1'b0) begin bad++; $display("FAIL w_empty_s0_wready got=%0b want=0", bus.s0_wready); end
        total++; if (bus.s1_wready !== 1'b0) begin bad++; $display("FAIL w_empty_s1_wready got=%0b want=0", bus.s1_wready); end
        bus.s0_wvalid = 1'b0;
        bus.s1_wvalid = 1'b0;
        bus.s0_wlast = 1'b0;
        bus.s1_wlast = 1'b0;
        tick();
    endtask

    task automatic test_fifo_full();
        int n;
        bus.s1_awid = 6'h33;
        bus.s1_awvalid = 1'b1;
        bus.m_awready = 1'b1;
        bus.m_wready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            tick();
            if (bus.m_awvalid) n++;
        end
        tick();
        total++; if (n !== 8) begin bad++; $display("FAIL full_grant_count got=%0d want=8", n); end
        repeat (4) tick();
        total++; if (bus.m_awvalid !== 1'b0) begin bad++; $display("FAIL full_no_grant got=%0b want=0", bus.m_awvalid); end
        total++; if (bus.s1_awready !== 1'b0) begin bad++; $display("FAIL full_awready got=%0b want=0", bus.s1_awready); end
        for (int b = 0; b < 4; b++) begin
            bus.s1_wvalid = 1'b1;
            bus.s1_wlast = (b == 3);
            bus.s1_wdata = {{(DATA_W-8){1'b0}}, 8'(b)};
            tick();
        end
        bus.s1_wvalid = 1'b0;
        bus.s1_wlast = 1'b0;
        #1;
        total++; if (bus.m_awvalid !== 1'b0) begin bad++; $display("FAIL full_pop_plus1 got=%0b want=0", bus.m_awvalid); end
        tick();
        total++; if (bus.m_awvalid !== 1'b1) begin bad++; $display("FAIL full_pop_plus2 got=%0b want=1", bus.m_awvalid); end
        total++; if (bus.s1_awready !== 1'b1) begin bad++; $display("FAIL full_regrant_ready got=%0b want=1", bus.s1_awready); end
        total++; if (bus.m_awid !== 7'h73) begin bad++; $display("FAIL full_regrant_id got=%h want=73", bus.m_awid); end
        tick();
        bus.s1_awvalid = 1'b0;
        bus.m_wready = 1'b0;
        do_reset();
    endtask

    task automatic test_r_route();
        bus.s0_rready = 1'b1;
        bus.s1_rready = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rid = 7'h45;
        bus.m_rdata = {{(DATA_W-32){1'b0}}, 32'hCAFE_0001};
        bus.m_rresp = 2'b01;
        bus.m_rlast = 1'b0;
        #1;
        total++; if (bus.s1_rvalid !== 1'b1) begin bad++; $display("FAIL r1_valid got=%0b want=1", bus.s1_rvalid); end
        total++; if (bus.s1_rid !== 6'h05) begin bad++; $display("FAIL r1_rid got=%h want=05", bus.s1_rid); end
        total++; if (bus.s1_rdata[31:0] !== 32'hCAFE_0001) begin bad++; $display("FAIL r1_rdata got=%h want=cafe0001", bus.s1_rdata[31:0]); end
        total++; if (bus.s0_rvalid !== 1'b0) begin bad++; $display("FAIL r1_other_valid got=%0b want=0", bus.s0_rvalid); end
        total++; if (bus.m_rready !== 1'b0) begin bad++; $display("FAIL r1_stall got=%0b want=0", bus.m_rready); end
        bus.s1_rready = 1'b1;
        #1;
        total++; if (bus.m_rready !== 1'b1) begin bad++; $display("FAIL r1_release got=%0b want=1", bus.m_rready); end
        tick();
        bus.s1_rready = 1'b0;
        bus.m_rid = 7'h05;
        bus.m_rdata = {{(DATA_W-32){1'b0}}, 32'hCAFE_0002};
        bus.m_rresp = 2'b00;
        bus.m_rlast = 1'b1;
        #1;
        total++; if (bus.s0_rvalid !== 1'b1) begin bad++; $display("FAIL r0_valid got=%0b want=1", bus.s0_rvalid); end
        total++; if (bus.s0_rid !== 6'h05) begin bad++; $display("FAIL r0_rid got=%h want=05", bus.s0_rid); end
        total++; if (bus.s0_rlast !== 1'b1) begin bad++; $display("FAIL r0_rlast got=%0b want=1", bus.s0_rlast); end
        total++; if (bus.s1_rvalid !== 1'b0) begin bad++; $display("FAIL r0_other_valid got=%0b want=0", bus.s1_rvalid); end
        total++; if (bus.m_rready !== 1'b1) begin bad++; $display("FAIL r0_no_stall got=%0b want=1", bus.m_rready); end
        tick();
        bus.m_rvalid = 1'b0;
        bus.m_rlast = 1'b0;
        bus.s0_rready = 1'b0;
    endtask

    task automatic test_b_route();
        bus.s0_bready = 1'b0;
        bus.s1_bready = 1'b1;
        bus.m_bvalid = 1'b1;
        bus.m_bid = 7'h7F;
        bus.m_bresp = 2'b10;
        #1;
        total++; if (bus.s1_bvalid !== 1'b1) begin bad++; $display("FAIL b1_valid got=%0b want=1", bus.s1_bvalid); end
        total++; if (bus.s1_bid !== 6'h3F) begin bad++; $display("FAIL b1_bid got=%h want=3f", bus.s1_bid); end
        total++; if (bus.s1_bresp !== 2'b10) begin bad++; $display("FAIL b1_bresp got=%0d want=2", bus.s1_bresp); end
        total++; if (bus.s0_bvalid !== 1'b0) begin bad++; $display("FAIL b1_other_valid got=%0b want=0", bus.s0_bvalid); end
        total++; if (bus.m_bready !== 1'b1) begin bad++; $display("FAIL b1_bready got=%0b want=1", bus.m_bready); end
        bus.m_bid = 7'h3F;
        #1;
        total++; if (bus.s0_bvalid !== 1'b1) begin bad++; $display("FAIL b0_valid got=%0b want=1", bus.s0_bvalid); end
        total++; if (bus.s1_bvalid !== 1'b0) begin bad++; $display("FAIL b0_other_valid got=%0b want=0", bus.s1_bvalid); end
        total++; if (bus.m_bready !== 1'b0) begin bad++; $display("FAIL b0_bready got=%0b want=0", bus.m_bready); end
        tick();
        bus.m_bvalid = 1'b0;
        bus.s1_bready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.s0_awid = 6'h01;
        bus.s1_awid = 6'h02;
        bus.s0_awvalid = 1'b1;
        bus.m_awready = 1'b1;
        tick();
        tick();
        bus.s0_awvalid = 1'b0;
        bus.s1_awvalid = 1'b1;
        bus.m_awready = 1'b0;
        tick();
        bus.s0_awvalid = 1'b1;
        bus.s0_wvalid = 1'b1;
        #1;
        total++; if (bus.m_awvalid !== 1'b1) begin bad++; $display("FAIL mid_pending_valid got=%0b want=1", bus.m_awvalid); end
        total++; if (bus.m_awid !== 7'h42) begin bad++; $display("FAIL mid_pending_id got=%h want=42", bus.m_awid); end
        total++; if (bus.m_wvalid !== 1'b1) begin bad++; $display("FAIL mid_fifo_head got=%0b want=1", bus.m_wvalid); end
        mc_rst = 1'b1;
        tick();
        total++; if (bus.m_awvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_awvalid got=%0b want=0", bus.m_awvalid); end
        total++; if (bus.m_wvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_fifo_empty got=%0b want=0", bus.m_wvalid); end
        mc_rst = 1'b0;
        bus.s0_wvalid = 1'b0;
        bus.m_awready = 1'b1;
        tick();
        total++; if (bus.m_awvalid !== 1'b1) begin bad++; $display("FAIL mid_first_grant got=%0b want=1", bus.m_awvalid); end
        total++; if (bus.m_awid !== 7'h01) begin bad++; $display("FAIL mid_first_grant_id got=%h want=01", bus.m_awid); end
        tick();
        bus.s0_awvalid = 1'b0;
        bus.s1_awvalid = 1'b0;
        bus.m_awready = 1'b0;
        tick();
    endtask

`ifdef AXI4_DDR_ARB_PERF_CNT_EN
    task automatic test_perf();
        int n;
        total++; if (perf_aw_cnt0 !== 32'd1) begin bad++; $display("FAIL perf_aw0 got=%0d want=1", perf_aw_cnt0); end
        bus.s0_arid = 6'h07;
        bus.s0_arvalid = 1'b1;
        bus.m_arready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if (bus.m_arvalid) n++;
        end
        tick();
        total++; if (perf_ar_cnt0 !== 32'd5) begin bad++; $display("FAIL perf_ar0_five got=%0d want=5", perf_ar_cnt0); end
        tick();
        total++; if (bus.m_arvalid !== 1'b1) begin bad++; $display("FAIL perf_sixth_grant got=%0b want=1", bus.m_arvalid); end
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        bus.s0_arvalid = 1'b0;
        bus.m_arready = 1'b0;
        #1;
        total++; if (perf_ar_cnt0 !== 32'd0) begin bad++; $display("FAIL perf_ar0_clr got=%0d want=0", perf_ar_cnt0); end
        total++; if (perf_ar_cnt1 !== 32'd0) begin bad++; $display("FAIL perf_ar1 got=%0d want=0", perf_ar_cnt1); end
        tick();
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        mc_rst = 1'b1;
        calib_done = 1'b0;
        init_inputs();
        test_reset();
        test_calib_gate();
        test_aw_round_robin();
        test_w_order();
        test_fifo_full();
        test_r_route();
        test_b_route();
        test_reset_mid();
`ifdef AXI4_DDR_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_ddr_arbiter.md
Name: axi4_ddr_arbiter

Overview:
- Shares the single DDR4 AXI4 slave port of the memory shell between two AXI4 masters in the mc_clk domain.
- Master 0 is the NoC-to-AXI4 bridge; master 1 is the PCIe/host DMA path.
- Arbitrates the AW and AR channels independently with round-robin, and steers W data in AW-grant order.
- Routes B and R responses back by an ID tag prepended by the arbiter; issues no grants until DDR calibration completes.

Parameters:
- ADDR_W, 64, AXI address width.
- DATA_W, 512, AXI data width; strobe width is DATA_W/8.
- ID_W, 6, master-side ID width; slave-side ID width is ID_W+1.
- WFIFO_DEPTH, 8, number of outstanding AW grants whose W bursts are not yet complete; power of 2, at least 2.

Ports:
- mc_clk  in  1  clock.
- mc_rst  in  1  synchronous, active-high reset.
- calib_done  in  1  DDR calibration complete; gates all grants.
- sN_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/ADDR_W/8/3/2/1  master N write address, N=0,1.
- sN_awready  out  1  write-address ready to master N.
- sN_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  master N write data.
- sN_wready  out  1  write-data ready to master N.
- sN_bid/bresp/bvalid  out  ID_W/2/1  write response to master N.
- sN_bready  in  1  write-response ready from master N.
- sN_arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/ADDR_W/8/3/2/1  master N read address.
- sN_arready  out  1  read-address ready to master N.
- sN_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data to master N.
- sN_rready  in  1  read-data ready from master N.
- m_aw*, m_w*, m_b*, m_ar*, m_r*  mirror  same widths, ID fields ID_W+1  slave-side bundle towards the memory shell.

Behaviour:
- Reset: all outputs 0, both arbiters IDLE, last-granted pointers = 1 (master 0 wins the first tie), W FIFO empty.
- AW arbiter FSM: IDLE, GNT0, GNT1.
  - IDLE -> GNTi when calib_done, the W FIFO is not full and some sN_awvalid is set. Winner is the requesting master other than last-granted; a sole requester wins.
  - In GNTi: m_aw* = si_aw* with m_awid = {i, si_awid}; m_awvalid = si_awvalid; si_awready = m_awready.
  - Grant is registered: one cycle from request to m_awvalid.
  - GNTi -> IDLE on the m_aw handshake; last-granted = i; push i into the W FIFO in the same cycle.
  - Grant is held until the handshake, even if the other master requests.
  - No back-to-back grant: at least one IDLE cycle between AW handshakes.
- AR arbiter: identical FSM, independent of AW; no FIFO condition; m_arid = {i, si_arid}.
- W steering:
  - When the FIFO is non-empty with head h: m_w* = sh_w*, sh_wready = m_wready; every other sN_wready = 0.
  - Pop on the handshake with wlast = 1.
  - When empty: m_wvalid = 0, all sN_wready = 0.
  - W beats never precede their AW grant.
- FIFO full is evaluated on registered occupancy. A pop in the same cycle does not enable a grant until the next cycle. Simultaneous push and pop keeps the count unchanged.
- B routing: k = m_bid[ID_W]. sk_bvalid = m_bvalid, sk_bid = m_bid[ID_W-1:0], m_bready = sk_bready; the other master's bvalid = 0. Purely combinational.
- R routing: same rule using m_rid[ID_W]; rlast, rdata and rresp pass through.
- calib_done low: arbiters stay in IDLE and all sN_awready/sN_arready = 0. A grant already issued completes normally.
- Reset mid-transaction returns to the reset state. Upstream masters are reset in the same domain by the same mc_rst.

Optional Feature:
- Macro: AXI4_DDR_ARB_PERF_CNT_EN.
- Defined:
  - Four 32-bit output counters: perf_aw_cnt0/1 and perf_ar_cnt0/1, each incrementing on its master's AW or AR handshake.
  - Counters wrap at 2^32-1 to 0.
  - Counters clear on mc_rst or on input perf_clr (1 bit). perf_clr has priority over an increment in the same cycle.
- Undefined: counters and perf_clr absent; no other change.

Test Plan:
- calib_done=0, s0_arvalid held high for 20 cycles -> m_arvalid stays 0. Raise calib_done -> m_arvalid=1 exactly 1 cycle later, m_arid={1'b0,s0_arid}.
- Both masters assert awvalid continuously, m_awready=1 -> grant sequence 0,1,0,1; m_awid MSBs 0,1,0,1. Each W burst (awlen=3, 4 beats) comes from the matching master in that order.
- Master 1 issues 8 AWs with W withheld (WFIFO_DEPTH=8) -> 9th AW is not granted (s1_awready=0). Complete one W burst -> 9th grant appears 2 cycles after its wlast handshake.
- Slave returns interleaved R beats with rid 7'h45 then 7'h05 -> first goes to master 1 with rid 6'h05, second to master 0 with rid 6'h05. s1_rready=0 stalls m_rready only for the master-1 beat.
- Assert mc_rst while GNT1 is pending with m_awready=0 -> next cycle m_awvalid=0, FIFO empty. The first grant after reset goes to master 0 on a tie.
- With AXI4_DDR_ARB_PERF_CNT_EN: 5 AR handshakes from master 0, then perf_clr together with a 6th handshake -> perf_ar_cnt0 = 5 before, 0 after.
